// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus-watching chain.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } i2c_state_t;

    localparam int   I2C_DATA_BITS = 8;
    localparam logic I2C_ACK       = 1'b0;

endpackage

// File: rtl/i2c_byte_decoder_if.sv
// Token stream from the byte decoder to the downstream pattern-matching FSM.
interface i2c_byte_decoder_if;
    import i2c_pkg::*;

    logic                     out_valid;
    logic                     out_ready;
    logic [I2C_DATA_BITS-1:0] byte_data;
    logic                     byte_ack;
    logic                     byte_first;
    logic                     start_evt;
    logic                     stop_evt;
    logic                     bus_busy;
    logic                     overrun;
    logic                     overrun_clr;

    modport master (
        output out_valid, byte_data, byte_ack, byte_first,
        output start_evt, stop_evt, bus_busy, overrun,
        input  out_ready, overrun_clr
    );

    modport slave (
        input  out_valid, byte_data, byte_ack, byte_first,
        input  start_evt, stop_evt, bus_busy, overrun,
        output out_ready, overrun_clr
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Synchroniser plus consecutive-sample glitch filter for one open-drain line.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic f,
    output logic f_prev
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       diff_cnt_reg;
    logic                   f_reg;
    logic                   f_prev_reg;
    logic                   s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= din;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign s = sync_reg[SYNC_STAGES-1];

    // The counter tracks how many consecutive cycles s has disagreed with f;
    // any agreeing cycle restarts the count, so short glitches never pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_cnt_reg <= '0;
            f_reg        <= 1'b1;
            f_prev_reg   <= 1'b1;
        end else begin
            f_prev_reg <= f_reg;
            if (s != f_reg) begin
                if (diff_cnt_reg == CNT_LAST) begin
                    f_reg        <= s;
                    diff_cnt_reg <= '0;
                end else begin
                    diff_cnt_reg <= diff_cnt_reg + 1'b1;
                end
            end else begin
                diff_cnt_reg <= '0;
            end
        end
    end

    assign f      = f_reg;
    assign f_prev = f_prev_reg;

endmodule

// File: rtl/i2c_byte_decoder.sv
// Decodes START/STOP and 8-bit+ACK bytes from filtered SDA/SCL into a valid/ready token stream.
module i2c_byte_decoder
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sda_in,
    input  logic                scl_in,
    i2c_byte_decoder_if.master  bus
);

    localparam int CNT_W = $clog2(I2C_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(I2C_DATA_BITS - 1);

    logic sda_f, sda_prev, scl_f, scl_prev;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .reset  (reset),
        .din    (sda_in),
        .f      (sda_f),
        .f_prev (sda_prev)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .reset  (reset),
        .din    (scl_in),
        .f      (scl_f),
        .f_prev (scl_prev)
    );

    // START/STOP need SCL high on both samples, so an SDA change coincident
    // with an SCL rise is treated purely as a data bit.
    logic start_det, stop_det, rise_det;
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;
    assign rise_det  = scl_f & ~scl_prev;

    i2c_state_t               state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [I2C_DATA_BITS-1:0] shift_reg;
    logic                     first_reg;
    logic                     busy_reg;
    logic                     start_evt_reg;
    logic                     stop_evt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            first_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            start_evt_reg <= 1'b0;
            stop_evt_reg  <= 1'b0;
        end else begin
            start_evt_reg <= start_det;
            stop_evt_reg  <= stop_det;
            if (start_det) begin
                state_reg <= DATA;
                cnt_reg   <= '0;
                first_reg <= 1'b1;
                busy_reg  <= 1'b1;
            end else if (stop_det) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                busy_reg  <= 1'b0;
            end else if (rise_det) begin
                case (state_reg)
                    DATA: begin
                        shift_reg <= {shift_reg[I2C_DATA_BITS-2:0], sda_f};
                        cnt_reg   <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) state_reg <= ACK;
                    end
                    ACK: begin
                        state_reg <= DATA;
                        cnt_reg   <= '0;
                        first_reg <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic byte_done, load;
    assign byte_done = (state_reg == ACK) & rise_det;
    assign load      = byte_done & (~bus.out_valid | bus.out_ready);

    logic                     out_valid_reg;
    logic [I2C_DATA_BITS-1:0] byte_data_reg;
    logic                     byte_ack_reg;
    logic                     byte_first_reg;
    logic                     overrun_reg;

    // The completed byte goes straight from the shift register and the live
    // ACK sample into the output stage, saving a cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            byte_data_reg  <= '0;
            byte_ack_reg   <= 1'b0;
            byte_first_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (load) begin
                out_valid_reg  <= 1'b1;
                byte_data_reg  <= shift_reg;
                byte_ack_reg   <= sda_f;
                byte_first_reg <= first_reg;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (byte_done && !load) overrun_reg <= 1'b1;
            else if (bus.overrun_clr) overrun_reg <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.byte_data  = byte_data_reg;
    assign bus.byte_ack   = byte_ack_reg;
    assign bus.byte_first = byte_first_reg;
    assign bus.start_evt  = start_evt_reg;
    assign bus.stop_evt   = stop_evt_reg;
    assign bus.bus_busy   = busy_reg;
    assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_i2c_byte_decoder.sv
// Self-checking bench: bit-banged I2C traffic against a byte-level transaction model.
module tb_i2c_byte_decoder;
    import i2c_pkg::*;

    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int H    = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sda_in = 1'b1;
    logic scl_in = 1'b1;
    logic ready_drv = 1'b1;
    logic ready_rnd = 1'b1;
    bit   rand_ready = 1'b0;

    i2c_byte_decoder_if bus();

    i2c_byte_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut (
        .clk    (clk),
        .reset  (reset),
        .sda_in (sda_in),
        .scl_in (scl_in),
        .bus    (bus)
    );

    assign bus.out_ready = rand_ready ? ready_rnd : ready_drv;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: expected tokens {first, ack, data}
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    bit first_pending = 1'b0;
    bit model_held    = 1'b0;
    bit exp_overrun   = 1'b0;

    int start_cnt = 0;
    int stop_cnt  = 0;
    int hold_err  = 0;
    int idle_cycles = 0;
    logic       prev_hold = 1'b0;
    logic [9:0] prev_fields = '0;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 ready_rnd = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && ({bus.byte_first, bus.byte_ack, bus.byte_data} !== prev_fields))
                hold_err++;
            prev_hold   = bus.out_valid && !bus.out_ready;
            prev_fields = {bus.byte_first, bus.byte_ack, bus.byte_data};
            if (bus.out_valid && bus.out_ready)
                got_q.push_back({bus.byte_first, bus.byte_ack, bus.byte_data});
            if (bus.start_evt) start_cnt++;
            if (bus.stop_evt)  stop_cnt++;
            if (!bus.bus_busy) idle_cycles++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_in = 1'b1; cyc(H);
        scl_in = 1'b1; cyc(H);
        sda_in = 1'b0; cyc(H);
        scl_in = 1'b0; cyc(H);
        first_pending = 1'b1;
    endtask

    task automatic i2c_stop();
        sda_in = 1'b0; cyc(H);
        scl_in = 1'b1; cyc(H);
        sda_in = 1'b1; cyc(H);
        first_pending = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sda_in = b;    cyc(H);
        scl_in = 1'b1; cyc(H);
        scl_in = 1'b0; cyc(H);
    endtask

    // Sends 8 data bits + ACK bit; optional 2-cycle SCL glitch after bit index glitch_after.
    task automatic send_byte(input logic [7:0] data, input logic ack, input bit check_lat,
                             input int glitch_after);
        for (int i = 7; i >= 0; i--) begin
            send_bit(data[i]);
            if (i == glitch_after) begin
                sda_in = 1'b0; cyc(H);
                scl_in = 1'b1; cyc(2);
                scl_in = 1'b0; cyc(H);
            end
        end
        sda_in = ack; cyc(H);
        scl_in = 1'b1;
        if (!rand_ready && !ready_drv && model_held) begin
            exp_overrun = 1'b1;
        end else begin
            exp_q.push_back({first_pending, ack, data});
            if (!rand_ready && !ready_drv) model_held = 1'b1;
        end
        first_pending = 1'b0;
        for (int k = 1; k <= H; k++) begin
            @(posedge clk); #1;
            if (check_lat && k == SYNC + FILT) begin
                checks++;
                if (bus.out_valid !== 1'b0)
                    $display("FAIL latency_early: out_valid=%0b at cycle %0d, required 0", bus.out_valid, k);
                if (bus.out_valid !== 1'b0) errors++;
            end
            if (check_lat && k == SYNC + FILT + 1) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency: out_valid=%0b at cycle %0d, required 1", bus.out_valid, k);
                end
            end
        end
        scl_in = 1'b0; cyc(H);
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(5);
        reset = 1'b0; cyc(100);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
        checks++; if (bus.byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %0h required 00", bus.byte_data); end
        checks++; if (bus.byte_ack !== 1'b0) begin errors++; $display("FAIL reset_byte_ack: got %0b required 0", bus.byte_ack); end
        checks++; if (bus.byte_first !== 1'b0) begin errors++; $display("FAIL reset_byte_first: got %0b required 0", bus.byte_first); end
        checks++; if (bus.start_evt !== 1'b0 || bus.stop_evt !== 1'b0) begin errors++; $display("FAIL reset_events: start=%0b stop=%0b required 0 0", bus.start_evt, bus.stop_evt); end
        checks++; if (bus.bus_busy !== 1'b0) begin errors++; $display("FAIL reset_bus_busy: got %0b required 0", bus.bus_busy); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b required 0", bus.overrun); end
        checks++; if (start_cnt != 0 || stop_cnt != 0) begin errors++; $display("FAIL reset_idle_events: starts=%0d stops=%0d required 0 0", start_cnt, stop_cnt); end
    endtask

    task automatic test_basic();
        int s0, p0;
        ready_drv = 1'b1;
        s0 = start_cnt; p0 = stop_cnt;
        i2c_start();
        checks++; if (bus.bus_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %0b required 1", bus.bus_busy); end
        send_byte(8'hA2, I2C_ACK, 1'b1, -1);
        send_byte(8'h5C, 1'b1, 1'b1, -1);
        i2c_stop();
        cyc(H);
        checks++; if (bus.bus_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_stop: got %0b required 0", bus.bus_busy); end
        checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin errors++; $display("FAIL basic_events: starts=%0d stops=%0d required 1 1", start_cnt - s0, stop_cnt - p0); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d: got {first,ack,data}=%03h required %03h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        int s0, p0;
        ready_drv = 1'b1;
        i2c_start();
        s0 = start_cnt; p0 = stop_cnt;
        send_byte(8'hA5, 1'b0, 1'b0, 4);
        checks++; if (start_cnt != s0 || stop_cnt != p0) begin errors++; $display("FAIL glitch_events: starts=%0d stops=%0d required 0 0", start_cnt - s0, stop_cnt - p0); end
        i2c_stop();
        cyc(H);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_byte%0d: got %03h required %03h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_overrun();
        ready_drv = 1'b0; model_held = 1'b0; exp_overrun = 1'b0;
        i2c_start();
        send_byte(8'h11, 1'b0, 1'b0, -1);
        send_byte(8'h22, 1'b0, 1'b0, -1);
        checks++; if (bus.out_valid !== 1'b1 || bus.byte_data !== 8'h11) begin errors++; $display("FAIL overrun_hold: valid=%0b data=%0h required 1 11", bus.out_valid, bus.byte_data); end
        checks++; if (bus.overrun !== exp_overrun) begin errors++; $display("FAIL overrun_set: got %0b required %0b", bus.overrun, exp_overrun); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL overrun_stable: %0d held-field changes, required 0", hold_err); end
        ready_drv = 1'b1; model_held = 1'b0;
        cyc(1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: out_valid=%0b required 0", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %0b required 1", bus.overrun); end
        bus.overrun_clr = 1'b1; cyc(1); bus.overrun_clr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %0b required 0", bus.overrun); end
        i2c_stop();
        cyc(H);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL overrun_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL overrun_byte%0d: got %03h required %03h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_repeated_start();
        int s0, p0, idle0;
        ready_drv = 1'b1;
        s0 = start_cnt; p0 = stop_cnt;
        i2c_start();
        idle0 = idle_cycles;
        send_byte(8'h3C, 1'b0, 1'b0, -1);
        i2c_start();
        send_byte(8'h81, 1'b1, 1'b0, -1);
        checks++; if (idle_cycles != idle0) begin errors++; $display("FAIL rstart_busy: bus_busy low for %0d cycles, required 0", idle_cycles - idle0); end
        checks++; if (start_cnt - s0 != 2 || stop_cnt != p0) begin errors++; $display("FAIL rstart_events: starts=%0d stops=%0d required 2 0", start_cnt - s0, stop_cnt - p0); end
        i2c_stop();
        cyc(H);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstart_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstart_byte%0d: got %03h required %03h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_abort();
        logic [7:0] d;
        ready_drv = 1'b1;
        i2c_start();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        i2c_stop();
        cyc(H);
        checks++; if (bus.bus_busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_stop: busy=%0b valid=%0b required 0 0", bus.bus_busy, bus.out_valid); end
        i2c_start();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        sda_in = 1'b1; cyc(H);
        reset = 1'b1; cyc(3); reset = 1'b0;
        first_pending = 1'b0;
        cyc(H);
        checks++; if (bus.bus_busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_reset: busy=%0b valid=%0b required 0 0", bus.bus_busy, bus.out_valid); end
        d = 8'($urandom);
        i2c_start();
        send_byte(d, 1'b0, 1'b0, -1);
        i2c_stop();
        cyc(H);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_byte%0d: got %03h required %03h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int n, s0, p0, ntx;
        s0 = start_cnt; p0 = stop_cnt;
        ntx = 4;
        rand_ready = 1'b1;
        for (int t = 0; t < ntx; t++) begin
            i2c_start();
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++)
                send_byte(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, -1);
            i2c_stop();
        end
        rand_ready = 1'b0; ready_drv = 1'b1;
        cyc(H);
        checks++; if (start_cnt - s0 != ntx || stop_cnt - p0 != ntx) begin errors++; $display("FAIL random_events: starts=%0d stops=%0d required %0d %0d", start_cnt - s0, stop_cnt - p0, ntx, ntx); end
        checks++; if (hold_err != 0 || bus.overrun !== 1'b0) begin errors++; $display("FAIL random_flow: hold_err=%0d overrun=%0b required 0 0", hold_err, bus.overrun); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte%0d: got %03h required %03h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus.overrun_clr = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_repeated_start();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
